// File: rtl/pixel_write_packer.sv
// pixel_write_packer
// Back end of the pixel pipeline. Blended 8-bit pixels are dithered (optional
// 4x4 ordered pattern), truncated to 5 bits per channel, tagged with the mask
// bit and merged into aligned 8-pixel VRAM blocks. The block is written as a
// single 128-bit word with a per-pixel select.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_valid / o_ready  input pixel handshake
//   i_x, i_y           pixel coordinates (10 / 9 bits)
//   i_r, i_g, i_b      blended colour, 8 bits each
//   i_ditherOn         apply ordered dither to this pixel
//   i_setMask          value for the written mask bit (bit 15)
//   i_flush            pulse: write out the partial block once the pipe drains
//   o_wrValid / i_wrReady  VRAM write handshake
//   o_wrY, o_wrBlk     block row and block column (x[9:3])
//   o_wrData           pixel k in bits [16k+15:16k]
//   o_wrSel            bit k set = pixel k written
//   o_busy             S1 holds a pixel, buffer non-empty, or flush pending
module pixel_write_packer (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [9:0]   i_x,
  input  logic [8:0]   i_y,
  input  logic [7:0]   i_r,
  input  logic [7:0]   i_g,
  input  logic [7:0]   i_b,
  input  logic         i_ditherOn,
  input  logic         i_setMask,
  input  logic         i_flush,
  output logic         o_wrValid,
  input  logic         i_wrReady,
  output logic [8:0]   o_wrY,
  output logic [6:0]   o_wrBlk,
  output logic [127:0] o_wrData,
  output logic [7:0]   o_wrSel,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // 4x4 ordered dither offset, indexed by {y[1:0], x[1:0]}.
  function automatic logic signed [3:0] dither_off(input logic [1:0] yy, input logic [1:0] xx);
    logic signed [3:0] d;
    case ({yy, xx})
      4'h0:    d = -4'sd4;
      4'h1:    d =  4'sd0;
      4'h2:    d = -4'sd3;
      4'h3:    d =  4'sd1;
      4'h4:    d =  4'sd2;
      4'h5:    d = -4'sd2;
      4'h6:    d =  4'sd3;
      4'h7:    d = -4'sd1;
      4'h8:    d = -4'sd3;
      4'h9:    d =  4'sd1;
      4'hA:    d = -4'sd4;
      4'hB:    d =  4'sd0;
      4'hC:    d =  4'sd3;
      4'hD:    d = -4'sd1;
      4'hE:    d =  4'sd2;
      4'hF:    d = -4'sd2;
      default: d =  4'sd0;
    endcase
    return d;
  endfunction

  // Add the signed offset in 10 bits, clamp to 0..255, keep the top 5 bits.
  function automatic logic [4:0] chan5(input logic [7:0] c, input logic signed [3:0] d);
    logic [9:0] sum;
    logic [7:0] clamped;
    sum = {2'b00, c} + {{6{d[3]}}, d};
    if (sum[9]) begin
      clamped = 8'd0;
    end else if (sum[8]) begin
      clamped = 8'hFF;
    end else begin
      clamped = sum[7:0];
    end
    return clamped[7:3];
  endfunction

  state_t         r_state;
  logic           r_s1_valid;
  logic [9:0]     r_s1_x;
  logic [8:0]     r_s1_y;
  logic [15:0]    r_s1_pix;
  logic [127:0]   r_buf_data;
  logic [7:0]     r_buf_sel;
  logic [8:0]     r_buf_y;
  logic [6:0]     r_buf_blk;
  logic           r_flush_pend;

  logic signed [3:0] w_d;
  logic [15:0]    w_pix;
  logic           w_same;
  logic           w_drain;
  logic           w_accept;
  logic [6:0]     w_shift;
  logic [7:0]     w_slot_bit;

  // Dither and pack the incoming pixel.
  always_comb begin
    if (i_ditherOn) begin
      w_d = dither_off(i_y[1:0], i_x[1:0]);
    end else begin
      w_d = 4'sd0;
    end
    w_pix = {i_setMask, chan5(i_b, w_d), chan5(i_g, w_d), chan5(i_r, w_d)};
  end

  assign w_same     = (r_s1_y == r_buf_y) && (r_s1_x[9:3] == r_buf_blk);
  // S1 only empties into the buffer when loading a fresh block or merging into the current one.
  assign w_drain    = r_s1_valid && ((r_state == ST_EMPTY) || ((r_state == ST_FILL) && w_same));
  assign o_ready    = !r_s1_valid || w_drain;
  assign w_accept   = i_valid && o_ready;
  assign w_shift    = {r_s1_x[2:0], 4'b0000};
  assign w_slot_bit = 8'd1 << r_s1_x[2:0];

  // S1 register, buffer FSM and flush-pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_s1_valid   <= 1'b0;
      r_s1_x       <= 10'd0;
      r_s1_y       <= 9'd0;
      r_s1_pix     <= 16'd0;
      r_buf_data   <= 128'd0;
      r_buf_sel    <= 8'd0;
      r_buf_y      <= 9'd0;
      r_buf_blk    <= 7'd0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_x     <= i_x;
        r_s1_y     <= i_y;
        r_s1_pix   <= w_pix;
      end else if (w_drain) begin
        r_s1_valid <= 1'b0;
      end

      r_flush_pend <= r_flush_pend | i_flush;

      case (r_state)
        ST_EMPTY: begin
          if (r_s1_valid) begin
            r_buf_data <= {112'd0, r_s1_pix} << w_shift;
            r_buf_sel  <= w_slot_bit;
            r_buf_y    <= r_s1_y;
            r_buf_blk  <= r_s1_x[9:3];
            r_state    <= ST_FILL;
          end else begin
            // Nothing to write: drop the request unless a pixel arrives with it.
            r_flush_pend <= i_flush & w_accept;
          end
        end
        ST_FILL: begin
          if (r_s1_valid && w_same) begin
            r_buf_data[w_shift +: 16] <= r_s1_pix;
            r_buf_sel <= r_buf_sel | w_slot_bit;
            if (r_buf_sel == 8'hFF) begin
              r_state <= ST_FLUSH;
            end else begin
              r_state <= ST_FILL;
            end
          end else if (r_s1_valid || (r_buf_sel == 8'hFF) || r_flush_pend) begin
            r_state <= ST_FLUSH;
          end else begin
            r_state <= ST_FILL;
          end
        end
        ST_FLUSH: begin
          if (i_wrReady) begin
            r_buf_sel <= 8'd0;
            r_state   <= ST_EMPTY;
            // A held pixel keeps the request alive so it is written after loading.
            if (!r_s1_valid) begin
              r_flush_pend <= 1'b0;
            end else begin
              r_flush_pend <= r_flush_pend;
            end
          end else begin
            r_state <= ST_FLUSH;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

  assign o_wrValid = (r_state == ST_FLUSH);
  assign o_wrY     = r_buf_y;
  assign o_wrBlk   = r_buf_blk;
  assign o_wrData  = r_buf_data;
  assign o_wrSel   = r_buf_sel;
  assign o_busy    = r_s1_valid || (r_buf_sel != 8'd0) || r_flush_pend;

endmodule

// File: tb/tb_pixel_write_packer.sv
module tb_pixel_write_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [9:0]   i_x;
  logic [8:0]   i_y;
  logic [7:0]   i_r, i_g, i_b;
  logic         i_ditherOn;
  logic         i_setMask;
  logic         i_flush;
  logic         o_wrValid;
  logic         i_wrReady;
  logic [8:0]   o_wrY;
  logic [6:0]   o_wrBlk;
  logic [127:0] o_wrData;
  logic [7:0]   o_wrSel;
  logic         o_busy;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;

  logic [127:0] m_data [0:15];
  logic [8:0]   m_y    [0:15];
  logic [6:0]   m_blk  [0:15];
  logic [7:0]   m_sel  [0:15];

  pixel_write_packer dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_y(i_y), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .i_ditherOn(i_ditherOn), .i_setMask(i_setMask), .i_flush(i_flush),
    .o_wrValid(o_wrValid), .i_wrReady(i_wrReady), .o_wrY(o_wrY),
    .o_wrBlk(o_wrBlk), .o_wrData(o_wrData), .o_wrSel(o_wrSel), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Record every completed write and every accepted pixel.
  always @(posedge clk) begin
    if (o_wrValid && i_wrReady) begin
      m_data[wr_cnt[3:0]] <= o_wrData;
      m_y[wr_cnt[3:0]]    <= o_wrY;
      m_blk[wr_cnt[3:0]]  <= o_wrBlk;
      m_sel[wr_cnt[3:0]]  <= o_wrSel;
      wr_cnt <= wr_cnt + 1;
    end
    if (i_valid && o_ready) begin
      acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [9:0] x, input logic [8:0] y, input logic [7:0] r,
                      input logic [7:0] g, input logic [7:0] b, input logic dth, input logic msk);
    int n;
    n = 0;
    i_valid = 1'b1; i_x = x; i_y = y; i_r = r; i_g = g; i_b = b;
    i_ditherOn = dth; i_setMask = msk;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    chk("send_bound", (n < 100), 1'b1);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k;
    k = 0;
    while (wr_cnt < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(tag, wr_cnt, n);
  endtask

  task automatic wait_wrvalid(input string tag);
    int k;
    k = 0;
    while (!o_wrValid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(tag, o_wrValid, 1'b1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_ready"},   o_ready,   1'b1);
    chk({pfx, "_wrvalid"}, o_wrValid, 1'b0);
    chk({pfx, "_wrdata"},  o_wrData,  128'd0);
    chk({pfx, "_wrsel"},   o_wrSel,   8'd0);
    chk({pfx, "_wry"},     o_wrY,     9'd0);
    chk({pfx, "_wrblk"},   o_wrBlk,   7'd0);
    chk({pfx, "_busy"},    o_busy,    1'b0);
  endtask

  initial begin
    logic [127:0] saved;
    logic         stable;
    int           a0;

    rst = 1'b1; i_valid = 1'b0; i_x = 10'd0; i_y = 9'd0;
    i_r = 8'd0; i_g = 8'd0; i_b = 8'd0; i_ditherOn = 1'b0; i_setMask = 1'b0;
    i_flush = 1'b0; i_wrReady = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single dithered pixel, then flush.
    send(10'd5, 9'd3, 8'h10, 8'h80, 8'hFF, 1'b1, 1'b1);
    pulse_flush();
    wait_writes(1, "t1_write");
    chk("t1_y",    m_y[0],           9'd3);
    chk("t1_blk",  m_blk[0],         7'd0);
    chk("t1_sel",  m_sel[0],         8'h20);
    chk("t1_data", m_data[0][95:80], 16'hFDE1);
    repeat (6) @(negedge clk);
    chk("t1_nodup", wr_cnt, 1);
    chk("t1_busy",  o_busy, 1'b0);

    // Full block, auto write three cycles after the eighth accept.
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      send(10'd16 + 10'(i), 9'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    end
    chk("t2_nostall", stalls, 0);
    chk("t2_c9_wrvalid", o_wrValid, 1'b0);
    @(negedge clk);
    chk("t2_c10_wrvalid", o_wrValid, 1'b0);
    @(negedge clk);
    chk("t2_c11_wrvalid", o_wrValid, 1'b1);
    chk("t2_sel",  o_wrSel,  8'hFF);
    chk("t2_blk",  o_wrBlk,  7'd2);
    chk("t2_y",    o_wrY,    9'd0);
    chk("t2_data", o_wrData, {8{16'h7FFF}});
    wait_writes(2, "t2_write");

    // Dither clamping at both ends; the y change forces a block write.
    send(10'd0, 9'd0, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0);
    send(10'd3, 9'd0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    send(10'd2, 9'd1, 8'h07, 8'h00, 8'h00, 1'b1, 1'b0);
    pulse_flush();
    wait_writes(4, "t3_writes");
    chk("t3a_y",     m_y[2],            9'd0);
    chk("t3a_sel",   m_sel[2],          8'h09);
    chk("t3a_slot0", m_data[2][15:0],   16'h0000);
    chk("t3a_slot3", m_data[2][63:48],  16'h001F);
    chk("t3b_y",     m_y[3],            9'd1);
    chk("t3b_sel",   m_sel[3],          8'h04);
    chk("t3b_slot2", m_data[3][47:32],  16'h0001);

    // Block change on x: first block written, second pixel held until flush.
    send(10'd7, 9'd10, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0);
    send(10'd8, 9'd10, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0);
    wait_writes(5, "t4_first");
    chk("t4a_blk",  m_blk[4],            7'd0);
    chk("t4a_sel",  m_sel[4],            8'h80);
    chk("t4a_y",    m_y[4],              9'd10);
    chk("t4a_data", m_data[4][127:112],  16'h4210);
    repeat (6) @(negedge clk);
    chk("t4_held",  wr_cnt, 5);
    chk("t4_busy",  o_busy, 1'b1);
    pulse_flush();
    wait_writes(6, "t4_second");
    chk("t4b_blk",  m_blk[5],          7'd1);
    chk("t4b_sel",  m_sel[5],          8'h01);
    chk("t4b_data", m_data[5][15:0],   16'h4210);

    // Backpressure for 20 cycles during a pending write.
    i_wrReady = 1'b0;
    send(10'd40, 9'd20, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0);
    pulse_flush();
    wait_wrvalid("t5_wrvalid");
    saved = o_wrData;
    a0 = acc_cnt;
    stable = 1'b1;
    i_valid = 1'b1; i_x = 10'd48; i_y = 9'd20;
    repeat (20) begin
      @(negedge clk);
      if (o_wrData !== saved || o_wrValid !== 1'b1) stable = 1'b0;
    end
    chk("t5_stable",   stable, 1'b1);
    chk("t5_accepts",  ((acc_cnt - a0) <= 1), 1'b1);
    chk("t5_nowrite",  wr_cnt, 6);
    chk("t5_ready",    o_ready, 1'b0);
    i_valid = 1'b0;
    i_wrReady = 1'b1;
    wait_writes(7, "t5_first");
    pulse_flush();
    wait_writes(8, "t5_second");
    chk("t5a_blk",  m_blk[6],        7'd5);
    chk("t5a_sel",  m_sel[6],        8'h01);
    chk("t5a_data", m_data[6][15:0], 16'h4210);
    chk("t5b_blk",  m_blk[7],        7'd6);
    chk("t5b_y",    m_y[7],          9'd20);
    chk("t5b_sel",  m_sel[7],        8'h01);
    repeat (10) @(negedge clk);
    chk("t5_nodup", wr_cnt, 8);

    // Reset while a write is outstanding.
    i_wrReady = 1'b0;
    send(10'd100, 9'd7, 8'h80, 8'h80, 8'h80, 1'b0, 1'b1);
    pulse_flush();
    wait_wrvalid("t6_wrvalid");
    #2 rst = 1'b1;
    #1 check_reset_outputs("t6");
    @(negedge clk);
    rst = 1'b0;
    i_wrReady = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_nowrite", wr_cnt, 8);
    chk("t6_busy",    o_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_write_packer.md
# pixel_write_packer

Back end of the pixel pipeline, after the blend unit. Takes blended 8-bit-per-channel pixels in stream order, applies optional 4x4 ordered dither, truncates to 5-bit channels, and sets the mask bit. Merges consecutive pixels of one aligned 8-pixel VRAM block into a 128-bit write with per-pixel select. Mirrors the VRAM read / 5-to-8 expansion path that feeds the blend unit's background inputs.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input pixel valid.
- o_ready  out  1  input pixel accepted when i_valid & o_ready.
- i_x  in  10  pixel X (0..1023).
- i_y  in  9  pixel Y (0..511).
- i_r, i_g, i_b  in  8 each  blended colour.
- i_ditherOn  in  1  apply dither to this pixel.
- i_setMask  in  1  value for the written mask bit (bit 15).
- i_flush  in  1  one-cycle pulse: emit the partial block once the pipe drains.
- o_wrValid  out  1  VRAM write request.
- i_wrReady  in  1  write accepted when o_wrValid & i_wrReady.
- o_wrY  out  9  block row.
- o_wrBlk  out  7  block column (x[9:3]).
- o_wrData  out  128  pixel k in bits [16k+15:16k].
- o_wrSel  out  8  bit k set = pixel k written.
- o_busy  out  1  S1 valid, buffer non-empty, or flush pending.

## Operation
- Stage S1, registered on input accept, holds x, y, and a 16-bit packed pixel {mask, b5, g5, r5}.
- Dither offset d by (y[1:0], x[1:0]):
  - row0: -4, 0, -3, 1
  - row1: 2, -2, 3, -1
  - row2: -3, 1, -4, 0
  - row3: 3, -1, 2, -2
- Per channel: 10-bit signed sum c + d (d = 0 when i_ditherOn = 0), clamped to 0..255; 5-bit result = clamped[7:3].
- Buffer FSM:
  - EMPTY: S1 valid → load S1 into slot x[2:0], latch y and x[9:3], set sel bit → FILL.
  - FILL, S1 valid, same y and x[9:3]: merge into the slot. A rewrite of the same slot overwrites it (last wins).
  - FILL, S1 valid, different block: → FLUSH. S1 holds its pixel.
  - FILL, sel becomes 8'hFF after a merge: → FLUSH next cycle (auto-flush).
  - FILL, flush pending, S1 empty: → FLUSH.
  - FLUSH: o_wrValid = 1. Data, sel, and address are stable until the handshake. On handshake, sel clears → EMPTY. The flush-pending flag also clears if S1 is empty.
- Flush-pending flag: set by i_flush, cleared on the FLUSH handshake. If the buffer is EMPTY and S1 is empty, it clears with no write issued.
- o_ready = !S1_valid | S1 drains this cycle. S1 drains only in EMPTY, or in FILL with a same-block match.

## Timing
- Reset values:
  - o_ready = 1.
  - o_wrValid = 0.
  - o_wrData = 0, o_wrSel = 0, o_wrY = 0, o_wrBlk = 0.
  - o_busy = 0.
  - FSM = EMPTY, S1 invalid, flush flag = 0.
- Reset mid-operation discards the buffer and S1 without a write. A write in progress is abandoned: o_wrValid drops asynchronously.
- Latency:
  - Accept at cycle N → S1 at N+1 → in buffer at N+2.
  - Full-block write visible at N+3 after accepting the 8th pixel.
- Throughput: one pixel/cycle while within one block and no write is outstanding.
- Block change costs at least 2 stall cycles: FLUSH handshake, then EMPTY load.
- i_wrReady held low: buffer and S1 freeze. o_ready stays 0 once S1 is full.
- i_flush arriving with S1 valid: the S1 pixel merges first, then the write issues.
- i_flush during FLUSH: flag is set but cleared by the current handshake, so no extra empty write.

## Test plan
- Single pixel (x=5, y=3, r=0x10, g=0x80, b=0xFF, dither on, mask 1), then i_flush:
  - (y&3=3, x&3=1) → d = -1.
  - r 0x0F → 1, g 0x7F → 15, b 0xFE → 31.
  - One write: y=3, blk=0, sel=8'h20, data[95:80]=16'hFDE1.
- 8 pixels x=16..23, y=0, r=g=b=0xFF, dither off:
  - One auto write, blk=2, sel=8'hFF, every slot 16'h7FFF.
  - Written at cycle 11 after the first accept; o_ready never drops.
- Dither clamp:
  - r=0x02 at (0,0) → 0.
  - r=0xFF at (x=3, y=0), d=+1 → 31.
  - r=0x07 at (x=2, y=1), d=+3 → 0x0A → 1.
- Block change: x=7 then x=8, same y → first write sel=8'h80, blk=0. Second pixel held and written after the next flush: blk=1, sel=8'h01.
- Backpressure: i_wrReady=0 for 20 cycles during FLUSH:
  - o_wrData stable throughout.
  - At most one additional pixel accepted.
  - No write lost or duplicated.
- Reset asserted while o_wrValid=1 → all outputs return to reset values immediately. No write follows after release.
